// File: rtl/gray_step_decoder_if.sv
// Sample/decode bundle between a Gray-counter source and gray_step_decoder.
// The source drives the sample side; the decoder drives everything else.
interface gray_step_decoder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic             gray_valid;
    logic [WIDTH-1:0] binary_out;
    logic             bin_valid;
    logic             dir;
    logic             wrap;
    logic             step_err;
    logic             locked;
    logic [7:0]       err_count;

    modport master (
        output gray_in, gray_valid,
        input  binary_out, bin_valid, dir, wrap, step_err, locked, err_count
    );

    modport slave (
        input  gray_in, gray_valid,
        output binary_out, bin_valid, dir, wrap, step_err, locked, err_count
    );
endinterface

// File: rtl/gray_step_decoder.sv
// Registers the binary decode of each accepted Gray sample and classifies the
// step from the previous sample as hold, up, down or illegal.
module gray_step_decoder #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    gray_step_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [WIDTH-1:0] MAX_CODE = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic             r_bin_valid;
    logic             r_dir;
    logic             r_wrap;
    logic             r_step_err;
    logic [7:0]       r_err_count;

    logic [WIDTH-1:0] w_decode;
    logic [WIDTH-1:0] w_delta;
    logic             w_hold;
    logic             w_up;
    logic             w_down;
    logic             w_legal;
    logic             w_illegal;
    logic             w_dir_nxt;
    logic             w_wrap;
    logic             w_step_err;

    // Binary bit i is the XOR of all Gray bits at or above position i.
    always_comb begin
        w_decode = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_decode[i] = ^(bus.gray_in >> i);
        end
    end

    assign w_delta   = w_decode - r_prev;
    assign w_hold    = (w_delta == '0);
    assign w_up      = (w_delta == {{(WIDTH-1){1'b0}}, 1'b1});
    assign w_down    = (w_delta == MAX_CODE);
    assign w_legal   = w_up | w_down;
    assign w_illegal = ~(w_hold | w_legal);

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_wrap      = 1'b0;
        w_step_err  = 1'b0;
        if (bus.gray_valid) begin
            case (r_state)
                IDLE:    w_state_nxt = ACQUIRE;
                ACQUIRE: begin
                    if (w_legal)   w_state_nxt = LOCKED;
                    if (w_illegal) w_step_err  = 1'b1;
                end
                LOCKED: begin
                    if (w_illegal) begin
                        w_state_nxt = ACQUIRE;
                        w_step_err  = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
            // The first sample after IDLE has no predecessor to compare against.
            if (r_state != IDLE && w_legal) begin
                w_dir_nxt = w_up;
                w_wrap    = (w_up && r_prev == MAX_CODE) || (w_down && r_prev == '0);
            end
        end
    end

    // NOTE: state is only ever written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // The last accepted decode doubles as prev and as binary_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= '0;
            r_bin_valid <= 1'b0;
            r_dir       <= 1'b1;
            r_wrap      <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_bin_valid <= bus.gray_valid;
            r_wrap      <= w_wrap;
            r_step_err  <= w_step_err;
            r_dir       <= w_dir_nxt;
            if (bus.gray_valid) r_prev <= w_decode;
            if (w_step_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.binary_out = r_prev;
    assign bus.bin_valid  = r_bin_valid;
    assign bus.dir        = r_dir;
    assign bus.wrap       = r_wrap;
    assign bus.step_err   = r_step_err;
    assign bus.locked     = (r_state == LOCKED);
    assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed and random stimulus for gray_step_decoder, compared every cycle
// against a behavioural model of the step-classification rules.
module tb_gray_step_decoder;
    localparam int W = 4;
    localparam int M = (1 << W);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    gray_step_decoder_if #(.WIDTH(W)) bus ();

    gray_step_decoder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: plain integers, not the DUT's encoding.
    int m_bin, m_prev, m_cnt;
    bit m_bv, m_dir, m_wrap, m_err, m_locked, m_seen;

    function automatic logic [W-1:0] to_gray(input int b);
        int v;
        v = b % M;
        return W'(v ^ (v >> 1));
    endfunction

    function automatic int from_gray(input logic [W-1:0] g);
        int b;
        b = 0;
        for (int k = 0; k < W; k++) b = b ^ (int'(g) >> k);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit v, input logic [W-1:0] g);
        int d, delta;
        m_bv = 0; m_wrap = 0; m_err = 0;
        if (rst) begin
            m_bin = 0; m_prev = 0; m_cnt = 0;
            m_dir = 1; m_locked = 0; m_seen = 0;
        end else if (v) begin
            d = from_gray(g);
            m_bv = 1;
            if (m_seen) begin
                delta = (d - m_prev + M) % M;
                if (delta == 1 || delta == M - 1) begin
                    m_dir    = (delta == 1);
                    m_wrap   = (m_prev == M - 1 && d == 0) || (m_prev == 0 && d == M - 1);
                    m_locked = 1;
                end else if (delta != 0) begin
                    m_err    = 1;
                    m_locked = 0;
                    m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end
            m_seen = 1;
            m_prev = d;
            m_bin  = d;
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [W-1:0] g);
        reset          = rst;
        bus.gray_valid = v;
        bus.gray_in    = g;
        @(posedge clk);
        #1;
        model(rst, v, g);
        check("binary_out", bus.binary_out, m_bin);
        check("bin_valid",  bus.bin_valid,  m_bv);
        check("dir",        bus.dir,        m_dir);
        check("wrap",       bus.wrap,       m_wrap);
        check("step_err",   bus.step_err,   m_err);
        check("locked",     bus.locked,     m_locked);
        check("err_count",  bus.err_count,  m_cnt);
    endtask

    initial begin
        int r;
        step(1, 0, '0);
        step(1, 0, '0);
        check("rst_dir", bus.dir, 1);

        // Count up 0..3
        step(0, 1, 4'b0000); check("up0_locked", bus.locked, 0);
        step(0, 1, 4'b0001); check("up1_locked", bus.locked, 1);
        step(0, 1, 4'b0011);
        step(0, 1, 4'b0010); check("up3_bin", bus.binary_out, 3);

        // Wrap up then down
        step(1, 0, '0);
        step(0, 1, to_gray(14));
        step(0, 1, 4'b1000);
        step(0, 1, 4'b0000); check("wrap_up", bus.wrap, 1); check("wrap_up_dir", bus.dir, 1);
        step(0, 1, 4'b1000); check("wrap_dn", bus.wrap, 1); check("wrap_dn_dir", bus.dir, 0);

        // Illegal step and relock
        step(1, 0, '0);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0010); check("ill_err", bus.step_err, 1); check("ill_cnt", bus.err_count, 1);
        step(0, 1, 4'b0110); check("relock", bus.locked, 1);

        // Hold and idle gaps
        step(0, 1, 4'b0110);
        step(0, 1, 4'b0110);
        for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, M - 1));
        check("gap_bin", bus.binary_out, 4);

        // Saturation, then reset with a simultaneous sample
        step(1, 0, '0);
        step(0, 1, 4'b0000);
        for (int i = 0; i < 300; i++) step(0, 1, (i % 2 == 0) ? 4'b0010 : 4'b0000);
        check("sat_cnt", bus.err_count, 255);
        step(1, 1, 4'b0111);
        check("rst_cnt", bus.err_count, 0);
        step(0, 1, 4'b0010); check("post_rst_err", bus.step_err, 0);

        // Random walk: mostly legal neighbours, some holds, jumps, gaps, resets
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    step(0, 1, to_gray(m_prev));
                2, 3, 4: step(0, 1, to_gray(m_prev + 1));
                5, 6:    step(0, 1, to_gray(m_prev + M - 1));
                7:       step(0, 1, $urandom_range(0, M - 1));
                8:       step(0, 0, $urandom_range(0, M - 1));
                default: step(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                              $urandom_range(0, M - 1));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_step_decoder.md
GRAY_STEP_DECODER -- requirements
Module: gray_step_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary code width in bits (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port gray_in, input, WIDTH bits: Gray-coded sample from an up/down Gray counter.
REQ-005 The block SHALL have port gray_valid, input, 1 bit: gray_in is sampled on this edge when high.
REQ-006 The block SHALL have port binary_out, output, WIDTH bits: registered binary decode of the last accepted sample.
REQ-007 The block SHALL have port bin_valid, output, 1 bit: one-cycle pulse marking a new binary_out.
REQ-008 The block SHALL have port dir, output, 1 bit: direction of the last legal step (1 = up, 0 = down).
REQ-009 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on a legal step across the max/0 boundary.
REQ-010 The block SHALL have port step_err, output, 1 bit: one-cycle pulse on an illegal step.
REQ-011 The block SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-012 The block SHALL have port err_count, output, 8 bits: saturating count of illegal steps.

Function
REQ-013 Decode SHALL be b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-014 With gray_valid high at edge N, binary_out SHALL show the decode and bin_valid SHALL be 1 after edge N (latency 1 cycle).
REQ-015 With gray_valid low, bin_valid, wrap and step_err SHALL be 0, and binary_out, dir, state and err_count SHALL hold.
REQ-016 The block SHALL store the last accepted decode as prev and compute delta = (decode - prev) mod 2^WIDTH.
REQ-017 Step classes: delta 0 = hold; delta 1 = up step; delta 2^WIDTH-1 = down step; any other delta = illegal.
REQ-018 The FSM SHALL have states IDLE, ACQUIRE and LOCKED.
REQ-019 IDLE with a valid sample SHALL go to ACQUIRE, load prev, and run no step check; step_err stays 0.
REQ-020 ACQUIRE with a legal up/down step SHALL go to LOCKED; hold SHALL stay in ACQUIRE.
REQ-021 ACQUIRE with an illegal step SHALL stay in ACQUIRE, pulse step_err, and take the new sample as prev.
REQ-022 LOCKED with hold or a legal step SHALL stay in LOCKED.
REQ-023 LOCKED with an illegal step SHALL go to ACQUIRE, pulse step_err, and take the new sample as prev.
REQ-024 dir SHALL update only on legal up/down steps; hold and illegal steps SHALL leave it unchanged.
REQ-025 wrap SHALL pulse when prev = 2^WIDTH-1 and decode = 0 (up), or prev = 0 and decode = 2^WIDTH-1 (down).
REQ-026 wrap, step_err and bin_valid SHALL all be aligned to the same cycle.
REQ-027 err_count SHALL increment by 1 on each step_err and saturate at 255 (no wrap to 0).
REQ-028 prev SHALL update on every accepted sample, in every state.

Reset
REQ-029 While reset is high at a clock edge, the outputs SHALL take: binary_out=0, bin_valid=0, dir=1, wrap=0, step_err=0, locked=0, err_count=0; prev SHALL be 0 and the state SHALL be IDLE.
REQ-030 Reset SHALL take priority over a simultaneous gray_valid; that sample is discarded.
REQ-031 Reset asserted mid-stream SHALL clear err_count and lock state; the first sample after reset SHALL be treated as in IDLE.

Verification (WIDTH=4)
REQ-032 Count up: reset, then gray_in 0000, 0001, 0011, 0010 on consecutive valid cycles -> binary_out 0, 1, 2, 3; locked rises after the 2nd sample; dir=1; step_err never asserts.
REQ-033 Wrap up, then down: locked at gray 1000 (bin 15), then gray 0000 -> binary_out 0, wrap=1, dir=1; then gray 1000 -> binary_out 15, wrap=1, dir=0.
REQ-034 Illegal step: locked at gray 0000, then gray 0010 (bin 3) -> step_err=1, err_count=1, locked=0 the next cycle; then gray 0110 (bin 4) -> locked=1.
REQ-035 Hold and idle gaps: the same gray value repeated, and gray_valid low for 5 cycles -> no step_err; bin_valid only on valid cycles; all outputs hold.
REQ-036 Saturation and reset: 300 alternating illegal samples (0000/0010) -> err_count=255; assert reset together with gray_valid -> all outputs at reset values; the next sample gives step_err=0.
